// File: rtl/axis_frame_tlast_packer_pkg.sv
// Shared constants and helpers for the frame packer and its FIFO.
// The default word and frame sizes are also used by the convolver wrapper.
package axis_frame_tlast_packer_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_FRAME_WORDS = 10000;

  // Each FIFO entry carries the data word plus its last tag.
  localparam int DEF_ENTRY_WIDTH = DEF_DATA_WIDTH + 1;

  // Smallest n with 2**n >= v; returns 0 for v <= 1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int entry_width_f(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; storage is not reset.
module axis_sync_fifo
  import axis_frame_tlast_packer_pkg::*;
#(
  parameter int WIDTH = DEF_ENTRY_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [clog2_f(DEPTH):0] o_level
);

  localparam int AW = clog2_f(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // Requests against a full/empty FIFO are ignored so the level can never wrap.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/axis_frame_tlast_packer.sv
// Buffers stream words ahead of the S2MM DMA, tags the last word of each
// frame and reports delivered frames to the control path.
module axis_frame_tlast_packer
  import axis_frame_tlast_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAME_WORDS  = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH   = 4,
  parameter int NB_FRAME_CNT = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         s_axis_valid,
  input  logic [DATA_WIDTH-1:0]        s_axis_data,
  output logic                         s_axis_ready,
  output logic                         m_axis_valid,
  output logic [DATA_WIDTH-1:0]        m_axis_data,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic                         o_frame_done,
  output logic [NB_FRAME_CNT-1:0]      o_frame_count,
  output logic [clog2_f(FIFO_DEPTH):0] o_fifo_level
);

  localparam int EW = entry_width_f(DATA_WIDTH);
  localparam int CW = (clog2_f(FRAME_WORDS) < 1) ? 1 : clog2_f(FRAME_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [NB_FRAME_CNT-1:0] FRAME_ONE = NB_FRAME_CNT'(1);

  logic [CW-1:0]           r_in_word_cnt;
  logic                    r_frame_done;
  logic [NB_FRAME_CNT-1:0] r_frame_count;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_last_tag;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  // Valid/ready: a word moves when valid and ready are both high at a rising
  // edge; s_axis_ready depends only on the registered level, and once
  // m_axis_valid is high the output word stays put until it is accepted.
  assign s_axis_ready = ~w_full;
  assign m_axis_valid = ~w_empty;
  assign w_push       = s_axis_valid & s_axis_ready;
  assign w_pop        = m_axis_valid & m_axis_ready;

  assign w_last_tag = (r_in_word_cnt == CNT_LAST);
  assign w_wdata    = {w_last_tag, s_axis_data};

  assign m_axis_data = w_rdata[DATA_WIDTH-1:0];
  assign m_axis_last = w_rdata[DATA_WIDTH];

  axis_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  // Frame position advances only on accepted words, so gaps never misalign it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_in_word_cnt <= '0;
    end else if (w_push) begin
      r_in_word_cnt <= w_last_tag ? '0 : (r_in_word_cnt + CNT_ONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= w_pop & m_axis_last;
      if (w_pop && m_axis_last) begin
        r_frame_count <= r_frame_count + FRAME_ONE;
      end
    end
  end

  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_axis_frame_tlast_packer.sv
// Directed and randomized checks of the frame packer against a queue model.
module tb_axis_frame_tlast_packer;

  localparam int DW = 32;
  localparam int FW = 8;
  localparam int FD = 4;
  localparam int NB = 2;

  // Clock / reset
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  logic          s_axis_valid = 1'b0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_ready;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b0;
  logic          o_frame_done;
  logic [NB-1:0] o_frame_count;
  logic [2:0]    o_fifo_level;

  axis_frame_tlast_packer #(
    .DATA_WIDTH   (DW),
    .FRAME_WORDS  (FW),
    .FIFO_DEPTH   (FD),
    .NB_FRAME_CNT (NB)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .s_axis_valid  (s_axis_valid),
    .s_axis_data   (s_axis_data),
    .s_axis_ready  (s_axis_ready),
    .m_axis_valid  (m_axis_valid),
    .m_axis_data   (m_axis_data),
    .m_axis_last   (m_axis_last),
    .m_axis_ready  (m_axis_ready),
    .o_frame_done  (o_frame_done),
    .o_frame_count (o_frame_count),
    .o_fifo_level  (o_fifo_level)
  );

  // Scoreboard: queue of {last, data} entries the DUT should be holding
  logic [DW:0]   exp_q[$];
  int            in_idx;
  logic          exp_done;
  logic [NB-1:0] exp_count;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_idx    = 0;
    exp_done  = 1'b0;
    exp_count = '0;
  endtask

  // Driver: apply inputs, check outputs mid-cycle, advance the model at the edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic mr);
    logic        push;
    logic        pop;
    logic [DW:0] head;
    s_axis_valid = v;
    s_axis_data  = d;
    m_axis_ready = mr;
    @(negedge i_clk);
    chk("s_ready", s_axis_ready, exp_q.size() != FD);
    chk("m_valid", m_axis_valid, exp_q.size() != 0);
    chk("level", o_fifo_level, exp_q.size());
    chk("frame_done", o_frame_done, exp_done);
    chk("frame_count", o_frame_count, exp_count);
    if (exp_q.size() != 0) begin
      chk("m_data", m_axis_data, exp_q[0][DW-1:0]);
      chk("m_last", m_axis_last, exp_q[0][DW]);
    end
    push = v && (exp_q.size() != FD);
    pop  = mr && (exp_q.size() != 0);
    @(posedge i_clk);
    exp_done = 1'b0;
    if (pop) begin
      head = exp_q.pop_front();
      if (head[DW]) begin
        exp_done  = 1'b1;
        exp_count = exp_count + 1'b1;
      end
    end
    if (push) begin
      exp_q.push_back({((in_idx % FW) == FW - 1), d});
      in_idx++;
    end
    #1;
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b1);
    chk("drain_level", o_fifo_level, 0);
    chk("drain_valid", m_axis_valid, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // Reset state
    step(1'b0, '0, 1'b0);

    // Streaming: 16 words, downstream always ready
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    chk("stream_count", o_frame_count, 2);

    // Backpressure: 6 offered words, only 4 fit
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, DW'(100 + i), 1'b0);
    chk("bp_level", o_fifo_level, 4);
    chk("bp_s_ready", s_axis_ready, 0);
    drain();

    // Simultaneous push and pop at level 2
    step(1'b1, 32'h200, 1'b0);
    step(1'b1, 32'h201, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h300 + i), 1'b1);
    chk("pp_level", o_fifo_level, 2);
    drain();

    // Reset after 3 words of a frame, then a full frame
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h400 + i), 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0);
    chk("rst_mid_valid", m_axis_valid, 0);
    for (int i = 0; i < FW; i++) step(1'b1, DW'(32'h500 + i), 1'b1);
    drain();
    chk("rst_mid_count", o_frame_count, 1);

    // Random gaps and random backpressure
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    drain();

    // Counter wrap: 5 frames through a 2-bit counter
    do_reset();
    for (int i = 0; i < 5 * FW; i++) step(1'b1, DW'(32'h600 + i), 1'b1);
    drain();
    chk("wrap_count", o_frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
